// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
//
// Bundles the pipeline-control signals exchanged between the pipeline stages
// and the central pipeline controller (pipe_ctrl).
//
// Requests (pipeline -> controller):
//   stallreq_if_i     fetch not ready
//   stallreq_id_i     load-use hazard
//   stallreq_ex_i     multi-cycle EX operation busy
//   stallreq_mem_i    data bus wait
//   ex_branch_flag_i  EX resolved a taken branch/jump this cycle
//   trap_req_i        MEM stage raises exception, interrupt or mret
//   trap_pc_i         redirect target, valid with trap_req_i
//
// Controls (controller -> pipeline):
//   stalled           per-stage stop: 0 pc, 1 if_id, 2 id_ex, 3 ex_mem,
//                     4 mem_wb, 5 wb
//   flush             per-stage kill, same bit mapping
//   new_pc_o          trap redirect target (registered)
//   new_pc_valid_o    one-cycle redirect strobe (registered)
//   stall_timeout_o   sticky stall watchdog flag
//
// Modports:
//   master  pipeline side (drives requests, consumes controls)
//   slave   controller side (consumes requests, drives controls)
// ----------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        ex_branch_flag_i;
    logic        trap_req_i;
    logic [31:0] trap_pc_i;

    logic [5:0]  stalled;
    logic [5:0]  flush;
    logic [31:0] new_pc_o;
    logic        new_pc_valid_o;
    logic        stall_timeout_o;

    modport master (
        output stallreq_if_i,
        output stallreq_id_i,
        output stallreq_ex_i,
        output stallreq_mem_i,
        output ex_branch_flag_i,
        output trap_req_i,
        output trap_pc_i,
        input  stalled,
        input  flush,
        input  new_pc_o,
        input  new_pc_valid_o,
        input  stall_timeout_o
    );

    modport slave (
        input  stallreq_if_i,
        input  stallreq_id_i,
        input  stallreq_ex_i,
        input  stallreq_mem_i,
        input  ex_branch_flag_i,
        input  trap_req_i,
        input  trap_pc_i,
        output stalled,
        output flush,
        output new_pc_o,
        output new_pc_valid_o,
        output stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//
// Central pipeline controller. Produces the per-stage stall and flush vectors
// for the pc, if_id, id_ex, ex_mem, mem_wb and wb registers.
//   - Stall requests are resolved by priority (mem > ex > id > if); every
//     stage upstream of the requester is stopped, the next one takes a bubble.
//   - A taken branch in EX flushes if_id and id_ex. If ex_mem is frozen that
//     cycle the flush is remembered and applied on the first unfrozen cycle.
//   - A trap from MEM waits for the data bus to drain, flushes stages 1..4 for
//     one cycle and issues a registered one-cycle PC redirect.
//   - A watchdog counts consecutive cycles with the pc stage stopped and sets
//     a sticky flag when STALL_TIMEOUT is reached.
//
// Parameters:
//   STALL_TIMEOUT  consecutive stalled cycles before the watchdog trips
//                  (1..65535)
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   pipe_ctrl_if.slave: stall/branch/trap requests in, stalled/flush,
//         redirect and watchdog flag out
//
// stalled/flush are combinational from the requests and the registered state
// (the pipeline registers act on the same edge); all other outputs are
// registered.
// ----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } trap_state_e;

    // Stall patterns: every stage up to and including the requester's input
    // register is stopped.
    localparam logic [5:0] STALL_NONE   = 6'b000000;
    localparam logic [5:0] STALL_IF     = 6'b000011;
    localparam logic [5:0] STALL_ID     = 6'b000111;
    localparam logic [5:0] STALL_EX     = 6'b001111;
    localparam logic [5:0] STALL_MEM    = 6'b011111;

    // Branch kills the two younger instructions (if_id, id_ex); a trap kills
    // everything between fetch and writeback.
    localparam logic [5:0] FLUSH_NONE   = 6'b000000;
    localparam logic [5:0] FLUSH_BRANCH = 6'b000110;
    localparam logic [5:0] FLUSH_TRAP   = 6'b011110;

    localparam logic [15:0] WD_LIMIT    = 16'(STALL_TIMEOUT);
    localparam logic [15:0] WD_MAX      = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    trap_state_e state_q;
    trap_state_e state_d;
    logic        br_pend_q;
    logic        br_pend_d;
    logic [31:0] trap_pc_q;
    logic [31:0] trap_pc_d;
    logic [15:0] wd_cnt_q;
    logic [31:0] new_pc_q;
    logic        new_pc_valid_q;
    logic        stall_timeout_q;

    // ------------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------------
    logic [5:0]  stall_prio;
    logic [5:0]  stalled_c;
    logic [5:0]  flush_c;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] wd_cnt_inc;

    // Priority resolution of the raw stall requests (used in IDLE).
    always_comb begin
        if (bus.stallreq_mem_i) begin
            stall_prio = STALL_MEM;
        end else if (bus.stallreq_ex_i) begin
            stall_prio = STALL_EX;
        end else if (bus.stallreq_id_i) begin
            stall_prio = STALL_ID;
        end else if (bus.stallreq_if_i) begin
            stall_prio = STALL_IF;
        end else begin
            stall_prio = STALL_NONE;
        end
    end

    // Trap FSM next state plus stall/flush/redirect decisions.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        br_pend_d   = br_pend_q;
        trap_pc_d   = trap_pc_q;
        stalled_c   = STALL_NONE;
        flush_c     = FLUSH_NONE;
        redirect    = 1'b0;
        redirect_pc = trap_pc_q;

        case (state_q)
            ST_IDLE: begin
                stalled_c = stall_prio;
                if (bus.trap_req_i) begin
                    // The trap flush supersedes any branch flush, so neither a
                    // new nor a pending branch flush is applied this cycle;
                    // br_pend is dropped when FLUSH is reached.
                    trap_pc_d = bus.trap_pc_i;
                    if (bus.stallreq_mem_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d     = ST_FLUSH;
                        redirect    = 1'b1;
                        redirect_pc = bus.trap_pc_i;
                    end
                end else if (bus.ex_branch_flag_i || br_pend_q) begin
                    // The branch flush must not hit if_id/id_ex while ex_mem is
                    // frozen (the branch is still sitting in EX); defer it.
                    if (stall_prio[3]) begin
                        br_pend_d = 1'b1;
                    end else begin
                        flush_c   = FLUSH_BRANCH;
                        br_pend_d = 1'b0;
                    end
                end
            end

            ST_DRAIN: begin
                // Hold everything below WB until the outstanding bus access
                // completes; lower-priority requests are irrelevant here.
                stalled_c = STALL_MEM;
                if (!bus.stallreq_mem_i) begin
                    state_d  = ST_FLUSH;
                    redirect = 1'b1;
                end
            end

            ST_FLUSH: begin
                flush_c   = FLUSH_TRAP;
                br_pend_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pipeline registers are being reset themselves; keep controls quiet.
        if (rst) begin
            stalled_c = STALL_NONE;
            flush_c   = FLUSH_NONE;
        end
    end

    // Saturating increment for the watchdog counter.
    assign wd_cnt_inc = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + 16'd1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            br_pend_q       <= 1'b0;
            trap_pc_q       <= 32'h0;
            wd_cnt_q        <= 16'h0;
            new_pc_q        <= 32'h0;
            new_pc_valid_q  <= 1'b0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_pend_q <= br_pend_d;
            trap_pc_q <= trap_pc_d;

            // Redirect is loaded on the edge that enters FLUSH, so the strobe
            // is visible during the FLUSH cycle; the target is held afterwards.
            new_pc_valid_q <= redirect;
            if (redirect) begin
                new_pc_q <= redirect_pc;
            end

            // Watchdog: count consecutive cycles with the pc stage stopped.
            if (stalled_c[0]) begin
                wd_cnt_q <= wd_cnt_inc;
                if (wd_cnt_inc >= WD_LIMIT) begin
                    stall_timeout_q <= 1'b1;
                end
            end else begin
                wd_cnt_q <= 16'h0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.stalled         = stalled_c;
    assign bus.flush           = flush_c;
    assign bus.new_pc_o        = new_pc_q;
    assign bus.new_pc_valid_o  = new_pc_valid_q;
    assign bus.stall_timeout_o = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Self-checking bench for pipe_ctrl (STALL_TIMEOUT = 4). A behavioural model
// describes the controller in terms of "how deep is the deepest requester",
// "is a trap waiting for the bus", "is this the trap-flush cycle" and a run
// length of stalled cycles. Every cycle all outputs are compared with the
// model; directed sequences additionally pin literal values.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .STALL_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    bit          m_trap_wait;   // trap accepted, bus access still outstanding
    bit          m_flush_now;   // current cycle is the trap flush cycle
    bit          m_br_pend;     // a branch flush is owed to the pipeline
    logic [31:0] m_target;
    logic [31:0] m_new_pc;
    bit          m_new_pc_valid;
    bit          m_timeout;
    int          m_run;         // consecutive cycles with pc stopped

    // Outputs observed in the most recent cycle
    logic [5:0]  obs_stalled;
    logic [5:0]  obs_flush;
    logic [31:0] obs_new_pc;
    logic        obs_valid;
    logic        obs_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_trap_wait    = 1'b0;
        m_flush_now    = 1'b0;
        m_br_pend      = 1'b0;
        m_target       = 32'h0;
        m_new_pc       = 32'h0;
        m_new_pc_valid = 1'b0;
        m_timeout      = 1'b0;
        m_run          = 0;
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model across the coming edge.
    task automatic cycle(input bit r, input bit rif, input bit rid, input bit rex,
                         input bit rmem, input bit br, input bit trap,
                         input logic [31:0] pc);
        logic [5:0] e_stalled;
        logic [5:0] e_flush;
        int         depth;

        @(negedge clk);
        rst                  = r;
        bus.stallreq_if_i    = rif;
        bus.stallreq_id_i    = rid;
        bus.stallreq_ex_i    = rex;
        bus.stallreq_mem_i   = rmem;
        bus.ex_branch_flag_i = br;
        bus.trap_req_i       = trap;
        bus.trap_pc_i        = pc;
        #2;

        // Expected combinational controls
        e_stalled = 6'b0;
        e_flush   = 6'b0;
        if (r) begin
            e_stalled = 6'b0;
        end else if (m_flush_now) begin
            e_flush = 6'b011110;
        end else if (m_trap_wait) begin
            e_stalled = 6'b011111;
        end else begin
            // Number of stopped registers = requesting stage index + 2.
            depth = rmem ? 5 : rex ? 4 : rid ? 3 : rif ? 2 : 0;
            e_stalled = 6'((1 << depth) - 1);
            if (!trap && (br || m_br_pend) && !e_stalled[3]) e_flush = 6'b000110;
        end

        obs_stalled = bus.stalled;
        obs_flush   = bus.flush;
        obs_new_pc  = bus.new_pc_o;
        obs_valid   = bus.new_pc_valid_o;
        obs_timeout = bus.stall_timeout_o;

        check("stalled", 32'(obs_stalled), 32'(e_stalled));
        check("flush", 32'(obs_flush), 32'(e_flush));
        check("new_pc", obs_new_pc, m_new_pc);
        check("new_pc_valid", 32'(obs_valid), 32'(m_new_pc_valid));
        check("stall_timeout", 32'(obs_timeout), 32'(m_timeout));

        // Advance the model
        if (r) begin
            model_reset();
        end else begin
            m_new_pc_valid = 1'b0;
            if (m_flush_now) begin
                m_flush_now = 1'b0;
                m_br_pend   = 1'b0;
            end else if (m_trap_wait) begin
                if (!rmem) begin
                    m_trap_wait    = 1'b0;
                    m_flush_now    = 1'b1;
                    m_new_pc       = m_target;
                    m_new_pc_valid = 1'b1;
                end
            end else if (trap) begin
                m_target = pc;
                if (rmem) begin
                    m_trap_wait = 1'b1;
                end else begin
                    m_flush_now    = 1'b1;
                    m_new_pc       = pc;
                    m_new_pc_valid = 1'b1;
                end
            end else if (br || m_br_pend) begin
                m_br_pend = e_stalled[3];
            end

            if (e_stalled[0]) begin
                m_run = (m_run < 65535) ? m_run + 1 : 65535;
                if (m_run >= TIMEOUT) m_timeout = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int valids;

        rst                  = 1'b1;
        bus.stallreq_if_i    = 1'b0;
        bus.stallreq_id_i    = 1'b0;
        bus.stallreq_ex_i    = 1'b0;
        bus.stallreq_mem_i   = 1'b0;
        bus.ex_branch_flag_i = 1'b0;
        bus.trap_req_i       = 1'b0;
        bus.trap_pc_i        = 32'h0;
        model_reset();

        // Reset: controls quiet even with every request raised
        cycle(1, 1, 1, 1, 1, 1, 1, 32'h55);
        check("rst_stalled", 32'(obs_stalled), 32'h0);
        check("rst_flush", 32'(obs_flush), 32'h0);
        cycle(1, 1, 1, 1, 1, 1, 1, 32'h55);
        idle();
        check("rst_new_pc", obs_new_pc, 32'h0);
        check("rst_valid", 32'(obs_valid), 32'h0);
        check("rst_timeout", 32'(obs_timeout), 32'h0);

        // Priority
        cycle(0, 0, 1, 1, 0, 0, 0, 32'h0);
        check("prio_id_ex", 32'(obs_stalled), 32'h0F);
        check("prio_id_ex_flush", 32'(obs_flush), 32'h0);
        cycle(0, 0, 1, 0, 0, 0, 0, 32'h0);
        check("prio_id", 32'(obs_stalled), 32'h07);

        // Branch without stall
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h0);
        check("br_flush", 32'(obs_flush), 32'h06);
        idle();
        check("br_flush_after", 32'(obs_flush), 32'h0);

        // Branch under a 3-cycle mem stall
        cycle(0, 0, 0, 0, 1, 1, 0, 32'h0);
        check("br_mem_stalled", 32'(obs_stalled), 32'h1F);
        check("br_mem_flush0", 32'(obs_flush), 32'h0);
        cycle(0, 0, 0, 0, 1, 0, 0, 32'h0);
        check("br_mem_flush1", 32'(obs_flush), 32'h0);
        cycle(0, 0, 0, 0, 1, 0, 0, 32'h0);
        check("br_mem_flush2", 32'(obs_flush), 32'h0);
        idle();
        check("br_pend_flush", 32'(obs_flush), 32'h06);
        idle();
        check("br_pend_done", 32'(obs_flush), 32'h0);

        // Trap without stall
        cycle(0, 0, 0, 0, 0, 0, 1, 32'h0000_0100);
        check("trap_req_flush", 32'(obs_flush), 32'h0);
        idle();
        check("trap_flush", 32'(obs_flush), 32'h1E);
        check("trap_flush_stalled", 32'(obs_stalled), 32'h0);
        check("trap_new_pc", obs_new_pc, 32'h100);
        check("trap_valid", 32'(obs_valid), 32'h1);
        idle();
        check("trap_valid_drop", 32'(obs_valid), 32'h0);
        check("trap_new_pc_hold", obs_new_pc, 32'h100);
        check("trap_after_flush", 32'(obs_flush), 32'h0);

        // Trap under a 2-cycle mem stall, second trap ignored
        valids = 0;
        cycle(0, 0, 0, 0, 1, 0, 1, 32'h0000_0200);
        valids += int'(obs_valid);
        check("drain_stalled0", 32'(obs_stalled), 32'h1F);
        cycle(0, 1, 1, 0, 1, 0, 1, 32'h0000_0300);
        valids += int'(obs_valid);
        check("drain_stalled1", 32'(obs_stalled), 32'h1F);
        cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        valids += int'(obs_valid);
        check("drain_stalled2", 32'(obs_stalled), 32'h1F);
        check("drain_no_flush", 32'(obs_flush), 32'h0);
        idle();
        valids += int'(obs_valid);
        check("drain_flush", 32'(obs_flush), 32'h1E);
        check("drain_new_pc", obs_new_pc, 32'h200);
        check("drain_valid", 32'(obs_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            idle();
            valids += int'(obs_valid);
        end
        check("drain_one_redirect", 32'(valids), 32'd1);
        check("drain_new_pc_hold", obs_new_pc, 32'h200);

        // Trap and branch together with a branch flush pending
        cycle(0, 0, 0, 0, 1, 1, 0, 32'h0);
        check("tb_pend_set", 32'(obs_flush), 32'h0);
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h0000_0400);
        check("tb_trap_wins", 32'(obs_flush), 32'h0);
        idle();
        check("tb_trap_flush", 32'(obs_flush), 32'h1E);
        check("tb_new_pc", obs_new_pc, 32'h400);
        idle();
        check("tb_no_branch1", 32'(obs_flush), 32'h0);
        idle();
        check("tb_no_branch2", 32'(obs_flush), 32'h0);

        // Watchdog
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        idle();
        check("wd_3_cycles", 32'(obs_timeout), 32'h0);
        idle();
        check("wd_3_cycles_b", 32'(obs_timeout), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 32'h0);
        check("wd_4th_cycle", 32'(obs_timeout), 32'h0);
        idle();
        check("wd_tripped", 32'(obs_timeout), 32'h1);
        idle();
        check("wd_sticky", 32'(obs_timeout), 32'h1);
        cycle(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle();
        check("wd_rst_clear", 32'(obs_timeout), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(199) == 0,
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 15,
                  $urandom_range(99) < 12,
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 15,
                  $urandom_range(99) < 6,
                  $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
